// File: rtl/writer_block_ram_pkg.sv
// writer_block_ram_pkg: default widths and writer state encoding shared by the prev-vector writer.
package writer_block_ram_pkg;
  localparam int MAX_NODES   = 8;
  localparam int INDEX_WIDTH = 3;
  localparam int VALUE_WIDTH = 8;
  localparam int MADDR_WIDTH = 16;
  localparam int MDATA_WIDTH = 16;
  localparam int MEM_DEPTH   = 256;
  typedef enum logic [1:0] {IDLE, WRITE, RELEASE, DONE} state_t;
endpackage

// File: rtl/writer_block_ram_block_ram.sv
// writer_block_ram_block_ram: single-port synchronous RAM with four-phase read/write handshakes.
module writer_block_ram_block_ram
  import writer_block_ram_pkg::*;
#(
  parameter int AW    = MADDR_WIDTH,
  parameter int DW    = MDATA_WIDTH,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_write_enable,
  input  logic          i_read_enable,
  output logic          o_write_ready,
  output logic          o_read_ready,
  output logic [DW-1:0] o_read_data
);
  localparam int IW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_write_ready, r_read_ready;
  logic [DW-1:0] r_read_data;
  logic [IW-1:0] w_idx;
  assign w_idx = IW'(i_addr % AW'(DEPTH));
  assign o_write_ready = r_write_ready;
  assign o_read_ready  = r_read_ready;
  assign o_read_data   = r_read_data;
  // Contents survive reset; only the handshake state is cleared.
  always_ff @(posedge i_clock)
    if (i_write_enable) r_mem[w_idx] <= i_wdata;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_write_ready <= 1'b0;
      r_read_ready  <= 1'b0;
      r_read_data   <= '0;
    end else begin
      r_write_ready <= i_write_enable;
      r_read_ready  <= i_read_enable & ~i_write_enable;
      if (i_read_enable & ~i_write_enable) r_read_data <= r_mem[w_idx];
    end
endmodule

// File: rtl/writer_block_ram.sv
// writer_block_ram: writes the prev vector into block RAM, then hands the RAM bus to a host read port.
module writer_block_ram
  import writer_block_ram_pkg::*;
#(
  parameter int MAX_NODES   = writer_block_ram_pkg::MAX_NODES,
  parameter int INDEX_WIDTH = writer_block_ram_pkg::INDEX_WIDTH,
  parameter int MADDR_WIDTH = writer_block_ram_pkg::MADDR_WIDTH,
  parameter int MDATA_WIDTH = writer_block_ram_pkg::MDATA_WIDTH,
  parameter int MEM_DEPTH   = writer_block_ram_pkg::MEM_DEPTH
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_enable,
  input  logic [MADDR_WIDTH-1:0]           i_starting_address,
  input  logic [MAX_NODES*INDEX_WIDTH-1:0] i_prev_vector,
  input  logic [INDEX_WIDTH-1:0]           i_number_of_nodes,
  output logic                             o_ready,
  input  logic                             i_rd_enable,
  input  logic [MADDR_WIDTH-1:0]           i_rd_addr,
  output logic                             o_rd_ready,
  output logic [MDATA_WIDTH-1:0]           o_rd_data
);
  localparam int CW     = INDEX_WIDTH + 1;
  localparam int STRIDE = MADDR_WIDTH / 8;
  state_t                 r_state;
  logic [CW-1:0]          r_count, r_i;
  logic [MADDR_WIDTH-1:0] r_addr;
  logic [MDATA_WIDTH-1:0] r_wdata;
  logic                   r_we, r_ready;
  logic [CW-1:0]          w_n, w_count, w_next_i;
  logic [INDEX_WIDTH-1:0] w_entry;
  logic                   w_bus, w_we, w_re, w_write_ready;
  logic [MADDR_WIDTH-1:0] w_addr;
  assign w_n      = CW'(i_number_of_nodes);
  assign w_count  = (w_n > CW'(MAX_NODES)) ? CW'(MAX_NODES) : w_n;
  assign w_next_i = r_i + CW'(1);
  assign w_entry  = i_prev_vector[INDEX_WIDTH*int'(w_next_i[INDEX_WIDTH-1:0]) +: INDEX_WIDTH];
  // Writer owns the RAM bus only while an entry is in flight.
  assign w_bus  = (r_state == WRITE) || (r_state == RELEASE);
  assign w_addr = w_bus ? r_addr : i_rd_addr;
  assign w_we   = w_bus & r_we;
  assign w_re   = ~w_bus & i_rd_enable;
  assign o_ready = r_ready;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_i     <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
    end else
      case (r_state)
        IDLE: if (i_enable) begin
          r_count <= w_count;
          r_i     <= '0;
          r_addr  <= i_starting_address;
          r_wdata <= MDATA_WIDTH'(i_prev_vector[INDEX_WIDTH-1:0]);
          r_we    <= w_count != '0;
          r_ready <= w_count == '0;
          r_state <= (w_count == '0) ? DONE : WRITE;
        end
        WRITE: if (w_write_ready) begin
          r_we    <= 1'b0;
          r_state <= RELEASE;
        end
        RELEASE: if (!w_write_ready) begin
          r_i     <= w_next_i;
          r_addr  <= r_addr + MADDR_WIDTH'(STRIDE);
          r_wdata <= MDATA_WIDTH'(w_entry);
          r_we    <= w_next_i != r_count;
          r_ready <= w_next_i == r_count;
          r_state <= (w_next_i == r_count) ? DONE : WRITE;
        end
        DONE: if (!i_enable) begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
  writer_block_ram_block_ram #(
    .AW(MADDR_WIDTH), .DW(MDATA_WIDTH), .DEPTH(MEM_DEPTH)
  ) u_ram (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_addr         (w_addr),
    .i_wdata        (r_wdata),
    .i_write_enable (w_we),
    .i_read_enable  (w_re),
    .o_write_ready  (w_write_ready),
    .o_read_ready   (o_rd_ready),
    .o_read_data    (o_rd_data)
  );
endmodule

// File: tb/tb_writer_block_ram.sv
// tb_writer_block_ram: directed checks of write-out, wrap, zero count, abort and host read arbitration.
module tb_writer_block_ram;
  logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, rd_enable = 1'b0;
  logic [15:0] starting_address = '0, rd_addr = '0;
  logic [23:0] prev_vector = '0;
  logic [2:0]  number_of_nodes = '0;
  logic        ready, rd_ready;
  logic [15:0] rd_data;
  int checks = 0, failures = 0;
  logic [2:0] v1 [8] = '{3'd5, 3'd3, 3'd7, 3'd1, 3'd0, 3'd6, 3'd2, 3'd4};
  logic [2:0] v2 [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] v3 [8] = '{3'd3, 3'd6, 3'd2, 3'd5, 3'd7, 3'd0, 3'd4, 3'd1};

  always #5 clock = ~clock;

  writer_block_ram dut (
    .i_clock            (clock),
    .i_reset            (reset),
    .i_enable           (enable),
    .i_starting_address (starting_address),
    .i_prev_vector      (prev_vector),
    .i_number_of_nodes  (number_of_nodes),
    .o_ready            (ready),
    .i_rd_enable        (rd_enable),
    .i_rd_addr          (rd_addr),
    .o_rd_ready         (rd_ready),
    .o_rd_data          (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pk(input logic [2:0] v [8]);
    pk = '0;
    for (int i = 0; i < 8; i++) pk[i*3 +: 3] = v[i];
  endfunction

  task automatic run(input logic [15:0] base, input logic [2:0] n);
    int k = 0;
    @(negedge clock);
    starting_address = base;
    number_of_nodes = n;
    enable = 1'b1;
    while (ready !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("ready_after_write", {31'd0, ready}, 32'd1);
  endtask

  task automatic finish_run;
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    @(negedge clock);
    rd_enable = 1'b1;
    rd_addr = a;
    @(negedge clock);
    check({tag, "_rdy"}, {31'd0, rd_ready}, 32'd1);
    check({tag, "_data"}, {16'd0, rd_data}, {16'd0, exp});
    rd_enable = 1'b0;
    @(negedge clock);
    check({tag, "_rdy_drop"}, {31'd0, rd_ready}, 32'd0);
  endtask

  initial begin
    int bad = 0;
    int k = 0;
    repeat (2) @(negedge clock);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    reset = 1'b0;
    // Full write-out at base 0, read back at stride 2
    prev_vector = pk(v1);
    run(16'h0000, 3'd7);
    for (int i = 0; i < 7; i++) rd(16'(2 * i), {13'd0, v1[i]}, "full");
    finish_run();
    // Zero count: ready quickly, RAM untouched
    run(16'h0040, 3'd1);
    finish_run();
    prev_vector = pk(v3);
    @(negedge clock);
    starting_address = 16'h0040;
    number_of_nodes = 3'd0;
    enable = 1'b1;
    @(negedge clock);
    check("zero_ready", {31'd0, ready}, 32'd1);
    finish_run();
    rd(16'h0040, 16'd5, "zero_unchanged");
    // Address wrap past 0xFFFF
    run(16'hFFFE, 3'd2);
    finish_run();
    rd(16'hFFFE, 16'd3, "wrap_e0");
    rd(16'h0000, 16'd6, "wrap_e1");
    // Reset during entry 3 of a write-out
    run(16'h0086, 3'd1);
    finish_run();
    prev_vector = pk(v2);
    @(negedge clock);
    starting_address = 16'h0080;
    number_of_nodes = 3'd7;
    enable = 1'b1;
    repeat (13) @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rd_ready", {31'd0, rd_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) rd(16'(16'h0080 + 2 * i), {13'd0, v2[i]}, "abort_kept");
    rd(16'h0086, 16'd3, "abort_e3_unwritten");
    prev_vector = pk(v3);
    run(16'h0080, 3'd7);
    finish_run();
    for (int i = 0; i < 7; i++) rd(16'(16'h0080 + 2 * i), {13'd0, v3[i]}, "rewrite");
    // Host read held during write-out is deferred until ready
    prev_vector = pk(v2);
    @(negedge clock);
    starting_address = 16'h0080;
    number_of_nodes = 3'd3;
    enable = 1'b1;
    @(negedge clock);
    rd_enable = 1'b1;
    rd_addr = 16'h0080;
    while (ready !== 1'b1 && k < 100) begin
      if (rd_ready !== 1'b0) bad++;
      @(negedge clock);
      k++;
    end
    check("busy_rd_blocked", bad, 0);
    check("busy_ready", {31'd0, ready}, 32'd1);
    check("busy_rd_ready_at_done", {31'd0, rd_ready}, 32'd0);
    @(negedge clock);
    check("busy_rd_ready", {31'd0, rd_ready}, 32'd1);
    check("busy_rd_data", {16'd0, rd_data}, 32'd1);
    rd_enable = 1'b0;
    finish_run();
    rd(16'h0082, 16'd2, "busy_e1");
    rd(16'h0084, 16'd3, "busy_e2");
    rd(16'h0086, 16'd5, "busy_beyond_count");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
